deserializador: RTL and testbench

DESERIALIZADOR -- requirements
Module: deserializador

---
 rtl/deserializador.sv | 88 ++++++++
 tb/tb_deserializador.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/deserializador.sv
// Serial-to-parallel receiver: start bit (0), ANCHO data bits, stop bit (1).
// Bit order is selectable per frame; only edges with enb=1 advance the frame.
module deserializador #(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  output logic [ANCHO-1:0] q,
  output logic             valid,
  output logic             err,
  output logic             ocupado,
  output logic [3:0]       cuenta
);

  localparam int CW = $clog2(ANCHO + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);

  typedef enum logic [1:0] {IDLE, DATOS, PARADA, ESPERA} estado_t;

  estado_t          state_q;
  logic [CW-1:0]    cnt_q;
  logic [ANCHO-1:0] sh_q;
  logic             dir_q;
  logic [ANCHO-1:0] q_q;
  logic             valid_q;
  logic             err_q;
  logic [3:0]       cuenta_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      dir_q    <= 1'b0;
      q_q      <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cuenta_q <= '0;
    end else begin
      // Pulses last one cycle regardless of enb.
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (enb) begin
        case (state_q)
          IDLE: begin
            if (!s_in) begin
              state_q <= DATOS;
              cnt_q   <= '0;
              sh_q    <= '0;
              dir_q   <= dir;
            end
          end
          DATOS: begin
            if (dir_q) sh_q <= {s_in, sh_q[ANCHO-1:1]};
            else       sh_q <= {sh_q[ANCHO-2:0], s_in};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == ULTIMO) state_q <= PARADA;
          end
          PARADA: begin
            if (s_in) begin
              q_q      <= sh_q;
              valid_q  <= 1'b1;
              cuenta_q <= cuenta_q + 4'd1;
              state_q  <= IDLE;
            end else begin
              err_q   <= 1'b1;
              state_q <= ESPERA;
            end
          end
          ESPERA: begin
            if (s_in) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign q       = q_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign cuenta  = cuenta_q;
  assign ocupado = (state_q == DATOS) || (state_q == PARADA);

endmodule

// File: tb/tb_deserializador.sv
// Directed bench for deserializador (ANCHO=4): per-scenario tasks with
// hand-computed expectations.
module tb_deserializador;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       enb;
  logic       dir;
  logic       s_in;
  logic [3:0] q;
  logic       valid;
  logic       err;
  logic       ocupado;
  logic [3:0] cuenta;

  int tests = 0;
  int fails = 0;

  deserializador #(.ANCHO(4)) dut (
    .clk(clk), .reset_L(reset_L), .enb(enb), .dir(dir), .s_in(s_in),
    .q(q), .valid(valid), .err(err), .ocupado(ocupado), .cuenta(cuenta)
  );

  always #5 clk = ~clk;

  // One enabled edge carrying bit b; returns 1 time unit after the edge.
  task automatic tick(input logic b);
    enb  = 1'b1;
    s_in = b;
    @(posedge clk);
    #1;
  endtask

  // Four data bits in line order for the given frame direction.
  task automatic send_data(input logic [3:0] d, input logic lsb_first);
    for (int i = 0; i < 4; i++) tick(lsb_first ? d[i] : d[3-i]);
  endtask

  task automatic test_reset;
    reset_L = 1'b0; enb = 1'b1; dir = 1'b0; s_in = 1'b0;
    #1;
    tests++;
    if ({q, valid, err, ocupado, cuenta} !== 11'd0) begin
      fails++;
      $display("FAIL reset_async: q=%b v=%b e=%b o=%b c=%0d, required all 0", q, valid, err, ocupado, cuenta);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({q, valid, err, ocupado, cuenta} !== 11'd0) begin
      fails++;
      $display("FAIL reset_held: q=%b v=%b e=%b o=%b c=%0d, required all 0", q, valid, err, ocupado, cuenta);
    end
    #2 reset_L = 1'b1; s_in = 1'b1;
  endtask

  task automatic test_msb_first;
    dir = 1'b0;
    tick(1'b0);
    tests++;
    if (ocupado !== 1'b1) begin fails++; $display("FAIL msb_ocupado: got %b, required 1", ocupado); end
    send_data(4'b1010, 1'b0);
    tests++;
    if (valid !== 1'b0) begin fails++; $display("FAIL msb_early_valid: got %b, required 0", valid); end
    tick(1'b1);
    tests++;
    if (valid !== 1'b1 || q !== 4'b1010 || cuenta !== 4'd1 || err !== 1'b0 || ocupado !== 1'b0) begin
      fails++;
      $display("FAIL msb_frame: v=%b q=%b c=%0d e=%b o=%b, required v=1 q=1010 c=1 e=0 o=0", valid, q, cuenta, err, ocupado);
    end
    tick(1'b1);
    tests++;
    if (valid !== 1'b0) begin fails++; $display("FAIL msb_pulse_width: valid=%b, required 0", valid); end
  endtask

  task automatic test_lsb_first;
    dir = 1'b1;
    tick(1'b0);
    send_data(4'b0001, 1'b1);
    tick(1'b1);
    tests++;
    if (valid !== 1'b1 || q !== 4'b0001 || cuenta !== 4'd2) begin
      fails++;
      $display("FAIL lsb_frame: v=%b q=%b c=%0d, required v=1 q=0001 c=2", valid, q, cuenta);
    end
    tick(1'b1);
  endtask

  task automatic test_frame_error;
    dir = 1'b0;
    tick(1'b0);
    send_data(4'b1111, 1'b0);
    tick(1'b0);
    tests++;
    if (err !== 1'b1 || valid !== 1'b0 || q !== 4'b0001 || cuenta !== 4'd2 || ocupado !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse: e=%b v=%b q=%b c=%0d o=%b, required e=1 v=0 q=0001 c=2 o=0", err, valid, q, cuenta, ocupado);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      tests++;
      if (err !== 1'b0 || ocupado !== 1'b0) begin
        fails++;
        $display("FAIL espera_hold[%0d]: e=%b o=%b, required e=0 o=0", i, err, ocupado);
      end
    end
    tick(1'b1);
    tick(1'b0);
    tests++;
    if (ocupado !== 1'b1) begin fails++; $display("FAIL espera_exit: ocupado=%b, required 1", ocupado); end
    send_data(4'b0110, 1'b0);
    tick(1'b1);
    tests++;
    if (valid !== 1'b1 || q !== 4'b0110 || cuenta !== 4'd3) begin
      fails++;
      $display("FAIL after_err_frame: v=%b q=%b c=%0d, required v=1 q=0110 c=3", valid, q, cuenta);
    end
  endtask

  task automatic test_enb_freeze;
    dir = 1'b0;
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    enb = 1'b0;
    dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_in = i[0];
      @(posedge clk);
      #1;
      tests++;
      if (ocupado !== 1'b1 || valid !== 1'b0 || err !== 1'b0) begin
        fails++;
        $display("FAIL freeze[%0d]: o=%b v=%b e=%b, required o=1 v=0 e=0", i, ocupado, valid, err);
      end
    end
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    tests++;
    if (valid !== 1'b1 || q !== 4'b1101 || cuenta !== 4'd4) begin
      fails++;
      $display("FAIL freeze_frame: v=%b q=%b c=%0d, required v=1 q=1101 c=4", valid, q, cuenta);
    end
    enb = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (valid !== 1'b0) begin fails++; $display("FAIL valid_clear_no_enb: valid=%b, required 0", valid); end
    dir = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    dir = 1'b0;
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    #2 reset_L = 1'b0;
    #1;
    tests++;
    if ({q, valid, err, ocupado, cuenta} !== 11'd0) begin
      fails++;
      $display("FAIL midframe_reset: q=%b v=%b e=%b o=%b c=%0d, required all 0", q, valid, err, ocupado, cuenta);
    end
    #2 reset_L = 1'b1;
    tick(1'b0);
    tests++;
    if (ocupado !== 1'b1 || valid !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_start: o=%b v=%b e=%b, required o=1 v=0 e=0", ocupado, valid, err);
    end
    send_data(4'b1001, 1'b0);
    tick(1'b1);
    tests++;
    if (valid !== 1'b1 || q !== 4'b1001 || cuenta !== 4'd1) begin
      fails++;
      $display("FAIL post_reset_frame: v=%b q=%b c=%0d, required v=1 q=1001 c=1", valid, q, cuenta);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] d;
    #1 reset_L = 1'b0;
    #2 reset_L = 1'b1;
    dir = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = 4'(i * 5 + 3);
      tick(1'b0);
      tests++;
      if (valid !== 1'b0 || ocupado !== 1'b1) begin
        fails++;
        $display("FAIL b2b_start[%0d]: v=%b o=%b, required v=0 o=1", i, valid, ocupado);
      end
      send_data(d, 1'b0);
      tick(1'b1);
      tests++;
      if (valid !== 1'b1 || q !== d || cuenta !== 4'(i + 1)) begin
        fails++;
        $display("FAIL b2b_frame[%0d]: v=%b q=%b c=%0d, required v=1 q=%b c=%0d", i, valid, q, cuenta, d, (i + 1) % 16);
      end
    end
    tick(1'b1);
    tests++;
    if (valid !== 1'b0 || cuenta !== 4'd0) begin
      fails++;
      $display("FAIL cuenta_wrap: v=%b c=%0d, required v=0 c=0", valid, cuenta);
    end
  endtask

  initial begin
    test_reset;
    test_msb_first;
    test_lsb_first;
    test_frame_error;
    test_enb_freeze;
    test_reset_mid_frame;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
